// File: rtl/decode_multi_pkg.sv
// Shared types for the multi-lane decode stage: opcodes, ALU/FU encodings and the decoded entry.
// DECODE_ILLEGAL_DETECT_EN adds an `illegal` flag to decoded_t.
package decode_multi_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    localparam logic [1:0] FU_ALU = 2'd0;
    localparam logic [1:0] FU_MUL = 2'd1;
    localparam logic [1:0] FU_DIV = 2'd2;
    localparam logic [1:0] FU_LSU = 2'd3;

    localparam logic [3:0] ALU_NONE = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_SLL  = 4'h2;
    localparam logic [3:0] ALU_SLT  = 4'h3;
    localparam logic [3:0] ALU_SLTU = 4'h4;
    localparam logic [3:0] ALU_XOR  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_SRA  = 4'h7;
    localparam logic [3:0] ALU_OR   = 4'h8;
    localparam logic [3:0] ALU_AND  = 4'h9;
    localparam logic [3:0] ALU_ADD  = 4'hA;
    localparam logic [3:0] ALU_PASS = 4'hB;   // result = imm (LUI, and AUIPC with pc folded in)
    localparam logic [3:0] ALU_BR   = 4'hC;
    localparam logic [3:0] ALU_JMP  = 4'hD;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [6:0]  opcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic [1:0]  fukind;
        logic [2:0]  subop;
        logic        dest_we;
        logic        pred_taken;
        logic [7:0]  bht_idx;
        logic [31:0] pred_target;
`ifdef DECODE_ILLEGAL_DETECT_EN
        logic        illegal;
`endif
    } decoded_t;

    // alt selects SUB over ADD and SRA over SRL.
    function automatic logic [3:0] alu_from_f3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/decode_multi_if.sv
// Instruction-queue to decode to dispatch bundle; master drives IQ lanes and dispatch controls.
interface decode_multi_if
    import decode_multi_pkg::*;
#(
    parameter int WIDTH = 2
);
    localparam int TW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0]        iq_valid;
    logic [WIDTH-1:0][31:0]  iq_pc;
    logic [WIDTH-1:0][31:0]  iq_inst;
    logic [WIDTH-1:0]        iq_pred_taken;
    logic [WIDTH-1:0][7:0]   iq_bht_idx;
    logic [WIDTH-1:0][31:0]  iq_pred_target;
    logic                    iq_ready;
    logic [WIDTH-1:0]        dec_valid;
    decoded_t [WIDTH-1:0]    dec_uop;
    logic [WIDTH-1:0][63:0]  dec_order;
    logic [TW-1:0]           dec_take;
    logic                    dec_flush;

    modport master (
        output iq_valid, iq_pc, iq_inst, iq_pred_taken, iq_bht_idx, iq_pred_target,
        input  iq_ready,
        input  dec_valid, dec_uop, dec_order,
        output dec_take, dec_flush
    );

    modport slave (
        input  iq_valid, iq_pc, iq_inst, iq_pred_taken, iq_bht_idx, iq_pred_target,
        output iq_ready,
        output dec_valid, dec_uop, dec_order,
        input  dec_take, dec_flush
    );

endinterface

// File: rtl/decode_multi_lane.sv
// Single-lane RV32IM decoder: instruction word plus prediction metadata -> decoded_t.
// DECODE_ILLEGAL_DETECT_EN flags unknown opcodes and bad OP funct7 values.
module decode_lane
    import decode_multi_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] inst,
    input  logic        pred_taken,
    input  logic [7:0]  bht_idx,
    input  logic [31:0] pred_target,
    output decoded_t    uop
);
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        rd_nz;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign rd_nz  = (inst[11:7] != 5'd0);
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    always_comb begin
        // NOTE: clear the whole entry first so every path drives every field and no latch is inferred.
        uop             = '0;
        uop.pc          = pc;
        uop.inst        = inst;
        uop.opcode      = opcode;
        uop.rs1         = inst[19:15];
        uop.rs2         = inst[24:20];
        uop.rd          = inst[11:7];
        uop.pred_taken  = pred_taken;
        uop.bht_idx     = bht_idx;
        uop.pred_target = pred_target;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                uop.rs1     = '0;
                uop.rs2     = '0;
                uop.imm     = (opcode == OPC_AUIPC) ? pc + imm_u : imm_u;
                uop.alu_op  = ALU_PASS;
                uop.dest_we = rd_nz;
            end
            OPC_JAL: begin
                uop.rs1     = '0;
                uop.rs2     = '0;
                uop.imm     = imm_j;
                uop.alu_op  = ALU_JMP;
                uop.dest_we = rd_nz;
            end
            OPC_JALR: begin
                uop.rs2     = '0;
                uop.imm     = imm_i;
                uop.alu_op  = ALU_JMP;
                uop.dest_we = rd_nz;
            end
            OPC_BRANCH: begin
                uop.imm    = imm_b;
                uop.alu_op = ALU_BR;
                uop.subop  = funct3;
            end
            OPC_LOAD, OPC_STORE: begin
                uop.imm     = (opcode == OPC_LOAD) ? imm_i : imm_s;
                uop.rs2     = (opcode == OPC_LOAD) ? 5'd0 : inst[24:20];
                uop.alu_op  = ALU_ADD;
                uop.fukind  = FU_LSU;
                uop.subop   = funct3;
                uop.dest_we = (opcode == OPC_LOAD) && rd_nz;
            end
            OPC_OP_IMM: begin
                uop.rs2     = '0;
                uop.imm     = imm_i;
                uop.alu_op  = alu_from_f3(funct3, (funct3 == 3'b101) && inst[30]);
                uop.dest_we = rd_nz;
            end
            OPC_OP: begin
                uop.dest_we = rd_nz;
                if (funct7 == F7_MULDIV) begin
                    uop.fukind = funct3[2] ? FU_DIV : FU_MUL;
                    uop.subop  = funct3;
                end else begin
                    uop.alu_op = alu_from_f3(funct3, funct7[5]);
`ifdef DECODE_ILLEGAL_DETECT_EN
                    uop.illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
`endif
                end
            end
            default: begin
                uop.rs1 = '0;
                uop.rs2 = '0;
`ifdef DECODE_ILLEGAL_DETECT_EN
                uop.illegal = 1'b1;
`endif
            end
        endcase
`ifdef DECODE_ILLEGAL_DETECT_EN
        // Illegal entries still flow to the ROB, which traps on them.
        if (uop.illegal) begin
            uop.dest_we = 1'b0;
            uop.fukind  = FU_ALU;
        end
`endif
    end

endmodule

// File: rtl/decode_multi.sv
// WIDTH-lane decode stage: decodes IQ lanes on enqueue into a DEPTH-entry circular buffer
// and presents the oldest WIDTH entries to dispatch with program-order tags.
module decode_multi
    import decode_multi_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
)(
    input  logic           clk,
    input  logic           rst,
    decode_multi_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    decoded_t        lane_uop [WIDTH];
    decoded_t        buf_q    [DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q;
    logic [63:0]     order_q;
    logic [CW-1:0]   n_enq, n_take;
    logic            accept;
    int              free_slots;

    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] base, input int off);
        return PW'((int'(base) + off) % DEPTH);
    endfunction

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        decode_lane u_lane (
            .pc          (bus.iq_pc[g]),
            .inst        (bus.iq_inst[g]),
            .pred_taken  (bus.iq_pred_taken[g]),
            .bht_idx     (bus.iq_bht_idx[g]),
            .pred_target (bus.iq_pred_target[g]),
            .uop         (lane_uop[g])
        );
    end

    // Readiness uses start-of-cycle occupancy only, so dispatch never feeds back into iq_ready.
    always_comb free_slots = DEPTH - int'(count_q);
    assign bus.iq_ready = !bus.dec_flush && (free_slots >= WIDTH);
    assign accept       = bus.iq_ready;
    assign n_take       = CW'(bus.dec_take);

    always_comb begin
        n_enq = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (accept && bus.iq_valid[i]) n_enq = n_enq + CW'(1);
        end
    end

    // NOTE: entry storage has no reset; head/count qualify it, so stale entries are never shown.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (accept && bus.iq_valid[i]) buf_q[wrap(tail_q, i)] <= lane_uop[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            order_q <= '0;
        end else if (bus.dec_flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= wrap(head_q, int'(bus.dec_take));
            tail_q  <= wrap(tail_q, int'(n_enq));
            count_q <= count_q + n_enq - n_take;
            order_q <= order_q + 64'(bus.dec_take);
        end
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            bus.dec_valid[i] = (i < int'(count_q));
            bus.dec_uop[i]   = buf_q[wrap(head_q, i)];
            bus.dec_order[i] = order_q + 64'(i);
        end
    end

    a_iq_contiguous : assert property (@(posedge clk) disable iff (rst)
        (bus.iq_valid & (bus.iq_valid + WIDTH'(1))) == '0);

    a_take_le_valid : assert property (@(posedge clk) disable iff (rst)
        int'(bus.dec_take) <= ((int'(count_q) < WIDTH) ? int'(count_q) : WIDTH));

endmodule

// File: tb/tb_decode_multi.sv
// Directed bench for decode_multi (WIDTH=2, DEPTH=4): hand sequences for queue behaviour,
// then a table of single-instruction decode vectors.
module tb_decode_multi;
    import decode_multi_pkg::*;

    localparam int WIDTH = 2;
    localparam int DEPTH = 4;
`ifdef DECODE_ILLEGAL_DETECT_EN
    localparam logic ILL_EN = 1'b1;
`else
    localparam logic ILL_EN = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic [1:0]  fukind;
        logic [2:0]  subop;
        logic        dest_we;
        logic        illegal;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_order;
    vec_t        vecs [14];

    decode_multi_if #(.WIDTH(WIDTH)) bus ();
    decode_multi #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] addi(input int rd, input int imm);
        return 32'((imm << 20) | (rd << 7) | 32'h13);
    endfunction

    task automatic set_lane(input int l, input logic [31:0] pc, input logic [31:0] inst);
        bus.iq_pc[l]          = pc;
        bus.iq_inst[l]        = inst;
        bus.iq_pred_taken[l]  = 1'b0;
        bus.iq_bht_idx[l]     = 8'h00;
        bus.iq_pred_target[l] = 32'h0;
    endtask

    initial begin
        vecs = '{
            '{"addi",   32'h0000, 32'h00500093, 5'd0, 5'd0,  32'd5,        4'hA, 2'd0, 3'd0, 1'b1, 1'b0},
            '{"mul",    32'h0004, 32'h02108133, 5'd1, 5'd1,  32'd0,        4'h0, 2'd1, 3'd0, 1'b1, 1'b0},
            '{"auipc",  32'h1000, 32'h00001197, 5'd0, 5'd0,  32'h2000,     4'hB, 2'd0, 3'd0, 1'b1, 1'b0},
            '{"sw",     32'h1004, 32'h00112223, 5'd2, 5'd1,  32'd4,        4'hA, 2'd3, 3'd2, 1'b0, 1'b0},
            '{"sub",    32'h1008, 32'h407302B3, 5'd6, 5'd7,  32'd0,        4'h1, 2'd0, 3'd0, 1'b1, 1'b0},
            '{"divu",   32'h100C, 32'h02A4D433, 5'd9, 5'd10, 32'd0,        4'h0, 2'd2, 3'd5, 1'b1, 1'b0},
            '{"beq",    32'h1010, 32'hFE208CE3, 5'd1, 5'd2,  32'hFFFFFFF8, 4'hC, 2'd0, 3'd0, 1'b0, 1'b0},
            '{"lw_x0",  32'h1014, 32'h0000A003, 5'd1, 5'd0,  32'd0,        4'hA, 2'd3, 3'd2, 1'b0, 1'b0},
            '{"jal",    32'h1018, 32'h010000EF, 5'd0, 5'd0,  32'd16,       4'hD, 2'd0, 3'd0, 1'b1, 1'b0},
            '{"lui",    32'h101C, 32'hABCDE237, 5'd0, 5'd0,  32'hABCDE000, 4'hB, 2'd0, 3'd0, 1'b1, 1'b0},
            '{"srai",   32'h1020, 32'h40335293, 5'd6, 5'd0,  32'h403,      4'h7, 2'd0, 3'd0, 1'b1, 1'b0},
            '{"addi_m1",32'h1024, 32'hFFF08093, 5'd1, 5'd0,  32'hFFFFFFFF, 4'hA, 2'd0, 3'd0, 1'b1, 1'b0},
            '{"all_one",32'h1028, 32'hFFFFFFFF, 5'd0, 5'd0,  32'd0,        4'h0, 2'd0, 3'd0, 1'b0, ILL_EN},
            '{"bad_f7", 32'h102C, 32'h042081B3, 5'd1, 5'd2,  32'd0,        4'hA, 2'd0, 3'd0, !ILL_EN, ILL_EN}
        };

        rst       = 1'b1;
        bus.iq_valid  = '0;
        bus.dec_take  = '0;
        bus.dec_flush = 1'b0;
        for (int l = 0; l < WIDTH; l++) set_lane(l, 32'h0, 32'h0);
        tick();
        tick();
        check("reset.dec_valid", 64'(bus.dec_valid), 64'b00);
        check("reset.iq_ready", 64'(bus.iq_ready), 64'd1);
        check("reset.order0", bus.dec_order[0], 64'd0);
        rst = 1'b0;
        tick();

        // Two-lane enqueue: ADDI x1,x0,5 and MUL x2,x1,x1.
        set_lane(0, 32'h0, 32'h00500093);
        set_lane(1, 32'h4, 32'h02108133);
        bus.iq_valid = 2'b11;
        tick();
        bus.iq_valid = 2'b00;
        #1;
        check("t1.dec_valid", 64'(bus.dec_valid), 64'b11);
        check("t1.l0.alu_op", 64'(bus.dec_uop[0].alu_op), 64'hA);
        check("t1.l0.imm", 64'(bus.dec_uop[0].imm), 64'd5);
        check("t1.l0.fukind", 64'(bus.dec_uop[0].fukind), 64'd0);
        check("t1.l1.fukind", 64'(bus.dec_uop[1].fukind), 64'd1);
        check("t1.l1.subop", 64'(bus.dec_uop[1].subop), 64'd0);
        check("t1.order0", bus.dec_order[0], 64'd0);
        check("t1.order1", bus.dec_order[1], 64'd1);

        // Fill to DEPTH with dec_take held at 0; a third pair must be refused.
        set_lane(0, 32'h8, addi(2, 2));
        set_lane(1, 32'hC, addi(3, 3));
        bus.iq_valid = 2'b11;
        #1;
        check("t2.ready_at2", 64'(bus.iq_ready), 64'd1);
        tick();
        set_lane(0, 32'h10, addi(4, 4));
        set_lane(1, 32'h14, addi(5, 5));
        #1;
        check("t2.ready_full", 64'(bus.iq_ready), 64'd0);
        tick();
        check("t2.still_full", 64'(bus.iq_ready), 64'd0);

        // Drain one per cycle with the third pair still offered.
        bus.dec_take = 2'd1;
        #1;
        check("t3.order_s0", bus.dec_order[0], 64'd0);
        tick();
        check("t3.ready_cnt3", 64'(bus.iq_ready), 64'd0);
        check("t3.order_s1", bus.dec_order[0], 64'd1);
        check("t3.mul_head", 64'(bus.dec_uop[0].fukind), 64'd1);
        tick();
        check("t3.ready_cnt2", 64'(bus.iq_ready), 64'd1);
        bus.dec_take = 2'd0;
        tick();
        bus.iq_valid = 2'b00;
        #1;
        check("t3.ready_refull", 64'(bus.iq_ready), 64'd0);
        check("t3.order_2", bus.dec_order[0], 64'd2);
        check("t3.order_3", bus.dec_order[1], 64'd3);
        check("t3.imm_2", 64'(bus.dec_uop[0].imm), 64'd2);
        check("t3.imm_3", 64'(bus.dec_uop[1].imm), 64'd3);
        bus.dec_take = 2'd2;
        tick();
        check("t3.order_4", bus.dec_order[0], 64'd4);
        check("t3.order_5", bus.dec_order[1], 64'd5);
        check("t3.wrap_pc4", 64'(bus.dec_uop[0].pc), 64'h10);
        check("t3.wrap_pc5", 64'(bus.dec_uop[1].pc), 64'h14);
        check("t3.wrap_imm5", 64'(bus.dec_uop[1].imm), 64'd5);
        tick();
        bus.dec_take = 2'd0;
        #1;
        check("t3.empty", 64'(bus.dec_valid), 64'b00);

        // Three buffered, then flush with enqueue and take also asserted.
        set_lane(0, 32'h20, addi(6, 6));
        set_lane(1, 32'h24, addi(7, 7));
        bus.iq_valid = 2'b11;
        tick();
        set_lane(0, 32'h28, addi(8, 8));
        bus.iq_valid = 2'b01;
        tick();
        check("t4.pre_valid", 64'(bus.dec_valid), 64'b11);
        check("t4.pre_order", bus.dec_order[0], 64'd6);
        set_lane(0, 32'h30, addi(9, 9));
        set_lane(1, 32'h34, addi(10, 10));
        bus.iq_valid  = 2'b11;
        bus.dec_take  = 2'd2;
        bus.dec_flush = 1'b1;
        #1;
        check("t4.ready_flush", 64'(bus.iq_ready), 64'd0);
        tick();
        bus.iq_valid  = 2'b00;
        bus.dec_take  = 2'd0;
        bus.dec_flush = 1'b0;
        #1;
        check("t4.post_valid", 64'(bus.dec_valid), 64'b00);
        check("t4.post_ready", 64'(bus.iq_ready), 64'd1);
        check("t4.post_order", bus.dec_order[0], 64'd6);
        bus.iq_valid = 2'b01;
        tick();
        bus.iq_valid = 2'b00;
        #1;
        check("t4.refill_valid", 64'(bus.dec_valid), 64'b01);
        check("t4.refill_pc", 64'(bus.dec_uop[0].pc), 64'h30);
        bus.dec_take = 2'd1;
        tick();
        bus.dec_take = 2'd0;
        exp_order = 64'd7;

        // Table of single-lane decode vectors.
        for (int v = 0; v < 14; v++) begin
            set_lane(0, vecs[v].pc, vecs[v].inst);
            bus.iq_pred_taken[0]  = v[0];
            bus.iq_bht_idx[0]     = 8'(v * 3);
            bus.iq_pred_target[0] = vecs[v].pc ^ 32'hF0;
            bus.iq_valid = 2'b01;
            tick();
            bus.iq_valid = 2'b00;
            #1;
            check({vecs[v].name, ".valid"},   64'(bus.dec_valid), 64'b01);
            check({vecs[v].name, ".order"},   bus.dec_order[0], exp_order);
            check({vecs[v].name, ".pc"},      64'(bus.dec_uop[0].pc), 64'(vecs[v].pc));
            check({vecs[v].name, ".inst"},    64'(bus.dec_uop[0].inst), 64'(vecs[v].inst));
            check({vecs[v].name, ".rs1"},     64'(bus.dec_uop[0].rs1), 64'(vecs[v].rs1));
            check({vecs[v].name, ".rs2"},     64'(bus.dec_uop[0].rs2), 64'(vecs[v].rs2));
            check({vecs[v].name, ".imm"},     64'(bus.dec_uop[0].imm), 64'(vecs[v].imm));
            check({vecs[v].name, ".alu_op"},  64'(bus.dec_uop[0].alu_op), 64'(vecs[v].alu_op));
            check({vecs[v].name, ".fukind"},  64'(bus.dec_uop[0].fukind), 64'(vecs[v].fukind));
            check({vecs[v].name, ".subop"},   64'(bus.dec_uop[0].subop), 64'(vecs[v].subop));
            check({vecs[v].name, ".dest_we"}, 64'(bus.dec_uop[0].dest_we), 64'(vecs[v].dest_we));
            check({vecs[v].name, ".ptaken"},  64'(bus.dec_uop[0].pred_taken), 64'(v[0]));
            check({vecs[v].name, ".bht"},     64'(bus.dec_uop[0].bht_idx), 64'(8'(v * 3)));
            check({vecs[v].name, ".ptgt"},    64'(bus.dec_uop[0].pred_target), 64'(vecs[v].pc ^ 32'hF0));
`ifdef DECODE_ILLEGAL_DETECT_EN
            check({vecs[v].name, ".illegal"}, 64'(bus.dec_uop[0].illegal), 64'(vecs[v].illegal));
`endif
            bus.dec_take = 2'd1;
            tick();
            bus.dec_take = 2'd0;
            exp_order = exp_order + 64'd1;
        end

        // Reset mid-operation overrides a concurrent flush and clears the order counter.
        set_lane(0, 32'h40, addi(1, 1));
        set_lane(1, 32'h44, addi(2, 2));
        bus.iq_valid = 2'b11;
        tick();
        bus.iq_valid = 2'b00;
        #1;
        check("rst.pre_order", bus.dec_order[0], exp_order);
        rst           = 1'b1;
        bus.dec_flush = 1'b1;
        tick();
        rst           = 1'b0;
        bus.dec_flush = 1'b0;
        #1;
        check("rst.valid", 64'(bus.dec_valid), 64'b00);
        check("rst.order", bus.dec_order[0], 64'd0);
        check("rst.ready", 64'(bus.iq_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
